// File: rtl/ssd_display_driver_pkg.sv
// Shared constants for the 7-segment display driver: segment patterns, converter FSM states, decode helpers.
package ssd_display_driver_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles render blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  function automatic longint pow10(input int n);
    pow10 = 1;
    for (int i = 0; i < n; i++) pow10 = pow10 * 10;
  endfunction

endpackage

// File: rtl/ssd_display_driver_if.sv
// Value-in / display-out bundle between the datapath debug output and the 7-segment pins.
interface ssd_display_driver_if #(
  parameter int DATA_W     = 13,
  parameter int NUM_DIGITS = 4
);
  logic [DATA_W-1:0]     value_in;
  logic [NUM_DIGITS-1:0] anode;
  logic [6:0]            cathode;
  logic                  dp;
  logic                  conv_busy;

  modport master (output value_in, input anode, cathode, dp, conv_busy);
  modport slave  (input value_in, output anode, cathode, dp, conv_busy);
endinterface

// File: rtl/ssd_display_driver_bin2bcd_seq.sv
// Sequential double-dabble: one bit per cycle, DATA_W shift cycles plus one DONE cycle.
module bin2bcd_seq
  import ssd_display_driver_pkg::*;
#(
  parameter int DATA_W     = 13,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_DIGITS*4-1:0] bcd_out
);
  localparam int BCD_W = NUM_DIGITS * 4;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [1:0]        state;
  logic [DATA_W-1:0] bin;
  logic [BCD_W-1:0]  bcd, adj;
  logic [CNT_W-1:0]  cnt;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      bin   <= '0;
      bcd   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          bin   <= bin_in;
          bcd   <= '0;
          cnt   <= '0;
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          {bcd, bin} <= {adj, bin} << 1;
          cnt        <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign bcd_out = bcd;
endmodule

// File: rtl/ssd_display_driver.sv
// Binary-to-decimal multiplexed 7-segment driver (common anode, active-low).
// Optional build macro SSD_LEADING_ZERO_BLANK_EN: blank leading zero digits (digit 0 always lit).
module ssd_display_driver
  import ssd_display_driver_pkg::*;
#(
  parameter int DATA_W      = 13,
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  ssd_display_driver_if.slave  bus
);
  localparam int BCD_W = NUM_DIGITS * 4;
  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (((longint'(1) << DATA_W) - 1) > (pow10(NUM_DIGITS) - 1)) begin : g_range_err
    $error("ssd_display_driver: DATA_W too wide for NUM_DIGITS decimal digits");
  end
  if (REFRESH_DIV < 2) begin : g_div_err
    $error("ssd_display_driver: REFRESH_DIV must be at least 2");
  end

  logic [DATA_W-1:0]     last_value;
  logic [BCD_W-1:0]      disp_reg, bcd_out;
  logic                  start, busy, done;
  logic [CNT_W-1:0]      refresh_cnt;
  logic [IDX_W-1:0]      dig_idx;
  logic [NUM_DIGITS-1:0] sel, blank_mask, anode_r;
  logic [3:0]            cur_nib;
  logic                  cur_blank;
  logic [6:0]            cathode_r;

  // A change is only consumed while the converter is idle; later edits wait their turn.
  assign start = (bus.value_in != last_value);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                last_value <= '0;
    else if (start && !busy) last_value <= bus.value_in;
  end

  bin2bcd_seq #(.DATA_W(DATA_W), .NUM_DIGITS(NUM_DIGITS)) u_conv (
    .clk(clk), .rst(rst), .start(start), .bin_in(bus.value_in),
    .busy(busy), .done(done), .bcd_out(bcd_out)
  );

  // Whole-word update keeps old and new digits from ever mixing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      disp_reg <= '0;
    else if (done) disp_reg <= bcd_out;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt <= '0;
      dig_idx     <= '0;
    end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      dig_idx     <= (dig_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : dig_idx + 1'b1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

`ifdef SSD_LEADING_ZERO_BLANK_EN
  logic zero_above;
  always_comb begin
    zero_above = 1'b1;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above    = zero_above & (disp_reg[i*4 +: 4] == 4'd0);
      blank_mask[i] = zero_above;
    end
  end
`else
  assign blank_mask = '0;
`endif

  always_comb begin
    cur_nib   = '0;
    cur_blank = 1'b0;
    sel       = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (dig_idx == IDX_W'(i)) begin
        cur_nib   = disp_reg[i*4 +: 4];
        cur_blank = blank_mask[i];
        sel[i]    = 1'b0;
      end
  end

  // Anode and cathode share one register stage so they always switch together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anode_r   <= '1;
      cathode_r <= SEG_BLANK;
    end else if (cur_blank) begin
      anode_r   <= '1;
      cathode_r <= SEG_BLANK;
    end else begin
      anode_r   <= sel;
      cathode_r <= seg_decode(cur_nib);
    end
  end

  assign bus.anode     = anode_r;
  assign bus.cathode   = cathode_r;
  assign bus.dp        = 1'b1;
  assign bus.conv_busy = busy;
endmodule

// File: tb/tb_ssd_display_driver.sv
// Bench for ssd_display_driver: table vectors, random values vs. a decimal model, and scan/latency/reset sequences.
module tb_ssd_display_driver;
  localparam int DW = 13, ND = 4, RD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ssd_display_driver_if #(.DATA_W(DW), .NUM_DIGITS(ND)) bus ();
  ssd_display_driver #(.DATA_W(DW), .NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    int          value;
    logic [15:0] bcd;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] prev_disp;
  logic [6:0]  seg_tab [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int p10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] bcd_of(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < ND; i++) r[i*4 +: 4] = 4'((v / p10(i)) % 10);
    return r;
  endfunction

  function automatic bit blank_digit(input int v, input int i);
`ifdef SSD_LEADING_ZERO_BLANK_EN
    return (i > 0) && (v < p10(i));
`else
    return 1'b0;
`endif
  endfunction

  // Lock onto the start of digit 0, then follow an ideal scan for two full rotations.
  task automatic scan_check(input int v, input string nm);
    logic [3:0] prev;
    logic [3:0] exp_an;
    logic [6:0] exp_cat;
    bit synced = 1'b0;
    int idx = 0, ph = 0, d;
    prev = bus.anode;
    for (int k = 0; k < 40 && !synced; k++) begin
      step();
      if (bus.anode == 4'hE && prev != 4'hE) synced = 1'b1;
      prev = bus.anode;
    end
    chk({nm, " scan sync"}, 32'(synced), 32'd1);
    if (synced) begin
      for (int k = 0; k < 2 * ND * RD; k++) begin
        d = (v / p10(idx)) % 10;
        if (blank_digit(v, idx)) begin
          exp_an  = 4'hF;
          exp_cat = 7'h7F;
        end else begin
          exp_an  = ~(4'b0001 << idx);
          exp_cat = seg_tab[d];
        end
        chk({nm, " anode"}, 32'(bus.anode), 32'(exp_an));
        chk({nm, " cathode"}, 32'(bus.cathode), 32'(exp_cat));
        step();
        ph++;
        if (ph == RD) begin
          ph  = 0;
          idx = (idx + 1) % ND;
        end
      end
    end
  endtask

  // Launch a new value right after an edge; display must hold old until edge 15 exactly.
  task automatic conv(input int v, input logic [15:0] exp, input string nm);
    bus.value_in = 13'(v);
    step();
    chk({nm, " busy"}, 32'(bus.conv_busy), 32'd1);
    repeat (13) step();
    chk({nm, " hold"}, 32'(dut.disp_reg), 32'(prev_disp));
    step();
    chk({nm, " latency"}, 32'(dut.disp_reg), 32'(exp));
    prev_disp = exp;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    bit   seen_busy;
    bit   legal;
    int   v, pv;

    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    vecs[0] = '{1234, 16'h1234};
    vecs[1] = '{8191, 16'h8191};
    vecs[2] = '{9,    16'h0009};
    vecs[3] = '{7,    16'h0007};
    vecs[4] = '{0,    16'h0000};
    vecs[5] = '{5678, 16'h5678};
    vecs[6] = '{1000, 16'h1000};
    vecs[7] = '{4095, 16'h4095};

    bus.value_in = '0;
    rst = 1'b0;
    repeat (3) step();
    chk("reset anode", 32'(bus.anode), 32'hF);
    chk("reset cathode", 32'(bus.cathode), 32'h7F);
    chk("reset dp", 32'(bus.dp), 32'd1);
    chk("reset busy", 32'(bus.conv_busy), 32'd0);
    chk("reset disp", 32'(dut.disp_reg), 32'd0);

    rst = 1'b1;
    seen_busy = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.conv_busy) seen_busy = 1'b1;
    end
    chk("zero no busy", 32'(seen_busy), 32'd0);
    chk("run dp", 32'(bus.dp), 32'd1);
    scan_check(0, "zero");
    prev_disp = 16'h0000;

    for (int i = 0; i < 8; i++) begin
      conv(vecs[i].value, vecs[i].bcd, $sformatf("vec%0d", i));
      scan_check(vecs[i].value, $sformatf("vec%0d", i));
    end

    pv = vecs[7].value;
    for (int i = 0; i < 12; i++) begin
      do v = int'($urandom_range(0, 8191)); while (v == pv);
      conv(v, bcd_of(v), $sformatf("rnd%0d", i));
      scan_check(v, $sformatf("rnd%0d", i));
      pv = v;
    end

    // Second change lands mid-SHIFT: 1234 completes first, then 5678, never a blend.
    if (pv != 17) conv(17, 16'h0017, "pre17");
    bus.value_in = 13'd1234;
    for (int e = 1; e <= 30; e++) begin
      step();
      if (e == 3) bus.value_in = 13'd5678;
      legal = (dut.disp_reg == 16'h0017) || (dut.disp_reg == 16'h1234) || (dut.disp_reg == 16'h5678);
      chk("midchg legal", 32'(legal), 32'd1);
      if (e == 14) chk("midchg old", 32'(dut.disp_reg), 32'h0017);
      if (e == 15) chk("midchg first", 32'(dut.disp_reg), 32'h1234);
      if (e == 29) chk("midchg hold", 32'(dut.disp_reg), 32'h1234);
      if (e == 30) chk("midchg second", 32'(dut.disp_reg), 32'h5678);
    end
    scan_check(5678, "midchg");

    // Reset pulled in the middle of SHIFT, released with 42 pending.
    bus.value_in = 13'd42;
    repeat (7) step();
    chk("mid busy", 32'(bus.conv_busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("rstmid anode", 32'(bus.anode), 32'hF);
    chk("rstmid cathode", 32'(bus.cathode), 32'h7F);
    chk("rstmid busy", 32'(bus.conv_busy), 32'd0);
    chk("rstmid disp", 32'(dut.disp_reg), 32'd0);
    repeat (2) step();
    chk("rstmid anode hold", 32'(bus.anode), 32'hF);
    chk("rstmid cathode hold", 32'(bus.cathode), 32'h7F);
    rst = 1'b1;
    prev_disp = 16'h0000;
    conv(42, 16'h0042, "postrst");
    scan_check(42, "postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
